// File: rtl/mips_pkg.sv
// Shared sbmips decode definitions: opcode and funct encodings, the decoded
// bundle carried by the decode stage, and the SPECIAL-funct legality table.
package mips_pkg;

    // Primary opcodes, inst[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LWL     = 6'h22;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SWL     = 6'h2a;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // SPECIAL funct codes, inst[5:0]
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_BREAK   = 6'h0d;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2a;
    localparam logic [5:0] FN_SLTU    = 6'h2b;

    // Decoded bundle registered alongside the raw instruction
    typedef struct packed {
        logic [4:0]  wdest;
        logic        we;
        logic [31:0] imm32;
        logic        illegal;
    } dec_bundle_t;

    // True when a SPECIAL funct is implemented by the core
    function automatic logic funct_legal(input logic [5:0] fn);
        logic ok;
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_JR, FN_JALR, FN_SYSCALL, FN_BREAK,
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: ok = 1'b1;
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Purely combinational decode of one (pc, inst) pair into write-back
// destination/enable, extended immediate, jump target and illegal flag.
module inst_field_decode
    import mips_pkg::*;
#(
    parameter int PC_W           = 30,
    parameter int ZERO_EXT_LOGIC = 1
) (
    input  logic [PC_W-1:0] pc,
    input  logic [31:0]     inst,
    output logic [4:0]      wdest,
    output logic            we,
    output logic [31:0]     imm32,
    output logic            illegal,
    output logic [PC_W-1:0] jtarget
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [31:0] sext;
    logic [31:0] zext;
    // The low PC bits are replaced by the 26-bit jump index
    logic [25:0] unused_pc_low;

    assign op            = inst[31:26];
    assign fn            = inst[5:0];
    assign rt_f          = inst[20:16];
    assign rd_f          = inst[15:11];
    assign sext          = {{16{inst[15]}}, inst[15:0]};
    assign zext          = {16'h0000, inst[15:0]};
    assign unused_pc_low = pc[25:0];

    // Jump target keeps the upper PC region and splices in the index
    assign jtarget = {pc[PC_W-1:26], inst[25:0]};

    // Opcode/funct classification; sign extension unless told otherwise
    always_comb begin
        wdest   = 5'd0;
        we      = 1'b0;
        imm32   = sext;
        illegal = 1'b0;
        case (op)
            OP_SPECIAL: begin
                wdest   = rd_f;
                we      = (rd_f != 5'd0);
                if (fn == FN_JR || fn == FN_SYSCALL || fn == FN_BREAK) begin
                    we = 1'b0;
                end
                illegal = !funct_legal(fn);
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J: begin
                we = 1'b0;
            end
            OP_JAL: begin
                wdest = 5'd31;
                we    = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU: begin
                wdest = rt_f;
                we    = (rt_f != 5'd0);
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                wdest = rt_f;
                we    = (rt_f != 5'd0);
                if (ZERO_EXT_LOGIC != 0) begin
                    imm32 = zext;
                end
            end
            OP_LUI: begin
                wdest = rt_f;
                we    = (rt_f != 5'd0);
                imm32 = {inst[15:0], 16'h0000};
            end
            OP_SB, OP_SH, OP_SWL, OP_SW: begin
                we = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_stage_hs.sv
// sbmips instruction-decode stage: one output register plus a one-entry skid
// buffer between fetch and register-read, with synchronous redirect flush.
//
// Handshake: a word moves on any rising edge where valid and ready are both
// high on that interface. in_ready is a pure function of registered state
// (high exactly when the skid is empty) and never looks at out_ready.
// out_valid stays high, with every field stable, until out_ready is seen.
module id_stage_hs
    import mips_pkg::*;
#(
    parameter int          PC_W           = 30,
    parameter int          ZERO_EXT_LOGIC = 1,
    parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [31:0]     imm32,
    output logic [PC_W-1:0] jtarget,
    output logic [4:0]      wdest,
    output logic            we,
    output logic            illegal
);

    // Skid buffer holds the raw word; it is decoded when it moves forward
    logic            skid_valid;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     skid_inst;

    // Output register contents
    logic [PC_W-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [PC_W-1:0] jt_q;
    dec_bundle_t     dec_q;

    // Decoder path, fed from the skid first so order is preserved
    logic [PC_W-1:0] src_pc;
    logic [31:0]     src_inst;
    logic [4:0]      d_wdest;
    logic            d_we;
    logic [31:0]     d_imm32;
    logic            d_illegal;
    logic [PC_W-1:0] d_jtarget;
    dec_bundle_t     dec_next;

    logic in_xfer;
    logic load;
    logic take;

    assign in_ready = !skid_valid;
    assign in_xfer  = in_valid & in_ready;
    assign load     = !out_valid | out_ready;
    assign take     = skid_valid | in_xfer;

    assign src_pc   = skid_valid ? skid_pc   : in_pc;
    assign src_inst = skid_valid ? skid_inst : in_inst;

    inst_field_decode #(
        .PC_W           (PC_W),
        .ZERO_EXT_LOGIC (ZERO_EXT_LOGIC)
    ) u_decode (
        .pc      (src_pc),
        .inst    (src_inst),
        .wdest   (d_wdest),
        .we      (d_we),
        .imm32   (d_imm32),
        .illegal (d_illegal),
        .jtarget (d_jtarget)
    );

    assign dec_next.wdest   = d_wdest;
    assign dec_next.we      = d_we;
    assign dec_next.imm32   = d_imm32;
    assign dec_next.illegal = d_illegal;

    // Stage registers: flush empties the stage but leaves field data in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= '0;
            pc_q       <= '0;
            inst_q     <= '0;
            jt_q       <= '0;
            dec_q      <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load) begin
            // Output slot is free: take skid if occupied, else a new input.
            // in_ready is low whenever skid is occupied, so both cannot race.
            out_valid  <= take;
            skid_valid <= 1'b0;
            if (take) begin
                pc_q   <= src_pc;
                inst_q <= src_inst;
                jt_q   <= d_jtarget;
                dec_q  <= dec_next;
            end
        end else if (in_xfer) begin
            // Output is stalled: park the raw word until the slot frees
            skid_valid <= 1'b1;
            skid_pc    <= in_pc;
            skid_inst  <= in_inst;
        end
    end

    assign out_pc   = pc_q;
    assign out_inst = out_valid ? inst_q : NOP_WORD;
    assign opcode   = inst_q[31:26];
    assign rs       = inst_q[25:21];
    assign rt       = inst_q[20:16];
    assign rd       = inst_q[15:11];
    assign shamt    = inst_q[10:6];
    assign funct    = inst_q[5:0];
    assign imm32    = dec_q.imm32;
    assign jtarget  = jt_q;
    assign wdest    = dec_q.wdest;
    assign we       = dec_q.we;
    assign illegal  = dec_q.illegal;

endmodule
